// File: rtl/sha_bus_pkg.sv
// Shared command-bus definitions: IDs, opcodes, command field layout, and the
// responder state type.
package sha_bus_pkg;

  localparam logic [1:0] ID_MEM  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_HASH = 2'b11;

  // Command word: {addr, rsvd[7:6], dest[5:4], src[3:2], op[1:0]}
  localparam int unsigned CMD_OP_LSB   = 0;
  localparam int unsigned CMD_SRC_LSB  = 2;
  localparam int unsigned CMD_DEST_LSB = 4;
  localparam int unsigned CMD_RSVD_LSB = 6;
  localparam int unsigned CMD_ADDR_LSB = 8;
  localparam int unsigned CMD_OP_W     = 2;
  localparam int unsigned CMD_ID_W     = 2;
  localparam int unsigned CMD_RSVD_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_SEND,
    ST_WR_RECV,
    ST_WR_REQ,
    ST_ACK
  } mcr_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_cmd_responder_if.sv
// Command / ack / tx / rx signal bundle between bus initiators and the memory responder.
interface mem_cmd_responder_if #(
  parameter int unsigned ADDRW = 24
);
  logic              cmd_valid;
  logic [ADDRW+7:0]  cmd_data;
  logic              cmd_ready;
  logic [2:0]        ack_out;
  logic [7:0]        tx_data;
  logic [1:0]        tx_dest;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output cmd_valid, cmd_data, tx_ready, rx_data, rx_valid,
    input  cmd_ready, ack_out, tx_data, tx_dest, tx_valid, rx_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, tx_ready, rx_data, rx_valid,
    output cmd_ready, ack_out, tx_data, tx_dest, tx_valid, rx_ready
  );
endinterface

// File: rtl/mem_cmd_responder.sv
// Memory-side responder: decodes read/write commands, streams RD_BYTES out of
// memory or collects WR_BYTES into memory one byte at a time, then pulses ack.
// Optional mem_ack watchdog: define MEM_CMD_RESPONDER_TIMEOUT_EN.
module mem_cmd_responder
  import sha_bus_pkg::*;
#(
  parameter int unsigned ADDRW          = 24,
  parameter logic [1:0]  MEM_ID         = ID_MEM,
  parameter int unsigned RD_BYTES       = 64,
  parameter int unsigned WR_BYTES       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_cmd_responder_if.slave bus,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic             err_out
);

  localparam int unsigned CNTW = $clog2(max_u(RD_BYTES, WR_BYTES)) + 1;

  mcr_state_e       r_state, w_state_nxt;
  logic [ADDRW-1:0] r_addr;
  logic [1:0]       r_dest;
  logic [CNTW-1:0]  r_cnt;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_wdata;

  logic [1:0]       w_op, w_src, w_dest;
  logic [ADDRW-1:0] w_cmd_addr;
  logic             w_ld_cmd, w_cnt_inc, w_cap_rd, w_cap_wr;
  logic             w_last_rd, w_last_wr, w_in_req, w_tmo_hit;
  logic             w_unused_rsvd;

  assign w_op          = bus.cmd_data[CMD_OP_LSB   +: CMD_OP_W];
  assign w_src         = bus.cmd_data[CMD_SRC_LSB  +: CMD_ID_W];
  assign w_dest        = bus.cmd_data[CMD_DEST_LSB +: CMD_ID_W];
  assign w_cmd_addr    = bus.cmd_data[CMD_ADDR_LSB +: ADDRW];
  assign w_unused_rsvd = ^bus.cmd_data[CMD_RSVD_LSB +: CMD_RSVD_W];

  assign w_last_rd = (r_cnt == CNTW'(RD_BYTES - 1));
  assign w_last_wr = (r_cnt == CNTW'(WR_BYTES - 1));
  assign w_in_req  = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);

`ifdef MEM_CMD_RESPONDER_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wdog;
  logic           r_err;

  assign w_tmo_hit = w_in_req && !mem_ack && (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
  assign err_out   = r_err;

  // Watchdog: counts stalled request cycles, restarts on ack or any state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      if (w_in_req && (w_state_nxt == r_state))
        r_wdog <= r_wdog + WDW'(1);
      else
        r_wdog <= '0;
    end
  end
`else
  localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;
  assign w_tmo_hit = 1'b0;
  assign err_out   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and bus/memory output drive
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_cmd      = 1'b0;
    w_cnt_inc     = 1'b0;
    w_cap_rd      = 1'b0;
    w_cap_wr      = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.ack_out   = 3'b000;
    bus.tx_valid  = 1'b0;
    bus.rx_ready  = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    unique case (r_state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if ((w_op == OP_RD) && (w_src == MEM_ID)) begin
            w_ld_cmd    = 1'b1;
            w_state_nxt = ST_RD_REQ;
          end else if ((w_op == OP_WR) && (w_dest == MEM_ID)) begin
            w_ld_cmd    = 1'b1;
            w_state_nxt = ST_WR_RECV;
          end
        end
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_addr + ADDRW'(r_cnt);
        if (mem_ack) begin
          w_cap_rd    = 1'b1;
          w_state_nxt = ST_RD_SEND;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_RD_SEND: begin
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_last_rd ? ST_ACK : ST_RD_REQ;
        end
      end
      ST_WR_RECV: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          w_cap_wr    = 1'b1;
          w_state_nxt = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_addr + ADDRW'(r_cnt);
        if (mem_ack) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = w_last_wr ? ST_ACK : ST_WR_RECV;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        bus.ack_out = {1'b1, MEM_ID};
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, byte counter and data capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_dest    <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_ld_cmd) begin
        r_addr <= w_cmd_addr;
        r_cnt  <= '0;
        if (w_op == OP_RD) r_dest <= w_dest;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
      if (w_cap_rd) r_tx_data <= mem_rdata;
      if (w_cap_wr) r_wdata   <= bus.rx_data;
    end
  end

  assign bus.tx_data = r_tx_data;
  assign bus.tx_dest = r_dest;
  assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_cmd_responder.sv
module tb_mem_cmd_responder;
  import sha_bus_pkg::*;

  localparam int unsigned ADDRW    = 24;
  localparam int unsigned RD_BYTES = 64;
  localparam int unsigned WR_BYTES = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cmd_responder_if #(.ADDRW(ADDRW)) bus();

  logic             mem_req, mem_we, err_out;
  logic [ADDRW-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata = 8'h00;
  logic             mem_ack = 1'b0;

  mem_cmd_responder #(
    .ADDRW(ADDRW), .MEM_ID(2'b00), .RD_BYTES(RD_BYTES), .WR_BYTES(WR_BYTES), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_out(err_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct { logic we; logic [23:0] addr; logic [7:0] data; } memop_t;
  typedef struct { logic [7:0] d; logic [1:0] dest; } txb_t;

  memop_t     exp_mem[$];
  txb_t       exp_tx[$];
  logic [7:0] rx_q[$];
  int         exp_acks = 0;
  logic [7:0] mem_arr [logic [23:0]];

  // Memory content: written bytes persist, untouched bytes read as addr[7:0]
  function automatic logic [7:0] memval(input logic [23:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a[7:0];
  endfunction

  int  cyc = 0;
  int  tx_seen = 0, acks_seen = 0, memops = 0, err_seen = 0;
  int  accept_cyc = 0, ack_cyc = 0;
  int  mem_lat = 0;
  bit  mem_hang = 0, rand_ready = 0, rx_gaps = 0, exp_err = 0;
  int  bp_trigger = -1, bp_cnt = 0;

  always @(posedge clk) cyc++;

  // ---------------- memory model (drives mem_ack/rdata, checks accesses) ----------------
  int mwait = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ack = 1'b0;
      mwait = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (mwait >= mem_lat && !mem_hang) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=addr %0h required=no access", mem_addr);
        end else begin
          memop_t e;
          e = exp_mem.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.data);
            mem_arr[mem_addr] = mem_wdata;
          end
        end
        mem_rdata = memval(mem_addr);
        mem_ack = 1'b1;
        mwait = 0;
        memops++;
      end else begin
        mwait++;
      end
    end else begin
      if (mwait != 0 && !mem_hang) chk("mem_req_held", mem_req, 1'b1);
      mwait = 0;
    end
  end

  // ---------------- tx consumer ----------------
  always @(posedge clk) begin
    #1;
    if (bp_cnt > 0) begin
      bus.tx_ready = 1'b0;
      bp_cnt--;
    end else if (bp_trigger >= 0 && tx_seen == bp_trigger && bus.tx_valid) begin
      bus.tx_ready = 1'b0;
      bp_cnt = 4;
      bp_trigger = -1;
    end else begin
      bus.tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- rx producer ----------------
  bit rx_hs = 0;
  always @(negedge clk) rx_hs = rst_n && bus.rx_valid && bus.rx_ready;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
    end else begin
      if (rx_hs && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_q.size() > 0 && (!rx_gaps || $urandom_range(0, 2) != 0)) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = rx_q[0];
      end else begin
        bus.rx_valid = 1'b0;
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  bit         tx_pend = 0, ack_prev = 0;
  logic [9:0] tx_held;
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_pend = 0;
      ack_prev = 0;
    end else begin
      if (bus.tx_valid) begin
        if (tx_pend) chk("tx_stable", {bus.tx_dest, bus.tx_data}, tx_held);
        if (bus.tx_ready) begin
          tx_pend = 0;
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected actual=%0h required=no byte", bus.tx_data);
          end else begin
            txb_t e;
            e = exp_tx.pop_front();
            chk("tx_byte", {bus.tx_dest, bus.tx_data}, {e.dest, e.d});
          end
          tx_seen++;
        end else begin
          tx_pend = 1;
          tx_held = {bus.tx_dest, bus.tx_data};
        end
      end else begin
        tx_pend = 0;
      end
      if (bus.ack_out != 3'b000) begin
        chk("ack_value", bus.ack_out, 3'b100);
        chk("ack_not_ready", bus.cmd_ready, 1'b0);
        chk("err_with_ack", err_out, exp_err);
        if (exp_acks == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected actual=%0h required=none", bus.ack_out);
        end else begin
          exp_acks--;
        end
        acks_seen++;
        ack_cyc = cyc;
        ack_prev = 1;
      end else if (ack_prev) begin
        chk("ready_after_ack", bus.cmd_ready, 1'b1);
        ack_prev = 0;
      end
      if (err_out) err_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [50:0] out_vec();
    return {bus.cmd_ready, bus.ack_out, bus.tx_valid, bus.tx_data, bus.tx_dest, bus.rx_ready,
            mem_req, mem_we, mem_addr, mem_wdata, err_out};
  endfunction

  localparam logic [50:0] RESET_VEC = {1'b1, 50'h0};

  // Model the command per the decode rules, queue expectations, then drive it
  task automatic issue_cmd(input logic [23:0] a, input logic [1:0] dest, input logic [1:0] src,
                           input logic [1:0] op, input bit ramp);
    logic [23:0] ad;
    logic [7:0]  d;
    bit          is_rd, is_wr, accepted;
    is_rd = (op == 2'b01) && (src == 2'b00);
    is_wr = (op == 2'b10) && (dest == 2'b00);
    if (is_rd && !mem_hang) begin
      for (int i = 0; i < RD_BYTES; i++) begin
        ad = a + 24'(i);
        exp_mem.push_back('{we: 1'b0, addr: ad, data: 8'h00});
        exp_tx.push_back('{d: memval(ad), dest: dest});
      end
    end
    if (is_wr) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        ad = a + 24'(i);
        d  = ramp ? 8'(8'hA0 + i) : 8'($urandom_range(0, 255));
        exp_mem.push_back('{we: 1'b1, addr: ad, data: d});
        rx_q.push_back(d);
      end
    end
    if (is_rd || is_wr) exp_acks++;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {a, 2'b00, dest, src, op};
    accepted = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        accept_cyc = cyc + 1;
        accepted = 1;
        break;
      end
    end
    chk("cmd_accepted", accepted, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_acks == 0 && exp_mem.size() == 0 && exp_tx.size() == 0 && bus.cmd_ready) break;
    end
    chk({"done_", name}, exp_acks + exp_mem.size() + exp_tx.size() + rx_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int a0, m0;
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    #1;
    chk("reset_outputs", out_vec(), RESET_VEC);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed read: 64 bytes from 0x100, dest 01, zero-wait memory
    a0 = acks_seen;
    issue_cmd(24'h000100, 2'b01, 2'b00, 2'b01, 0);
    wait_done("read", 3000);
    chk("read_ack_count", acks_seen - a0, 1);

    // Directed write: 32 ramp bytes to 0x200 with rx gaps
    rx_gaps = 1;
    a0 = acks_seen;
    issue_cmd(24'h000200, 2'b00, 2'b01, 2'b10, 1);
    wait_done("write", 3000);
    chk("write_ack_count", acks_seen - a0, 1);

    // Backpressure on byte 3 plus 3-cycle memory latency; reads back written data
    mem_lat = 3;
    bp_trigger = tx_seen + 3;
    issue_cmd(24'h000200, 2'b10, 2'b00, 2'b01, 0);
    wait_done("backpressure", 3000);
    mem_lat = 0;

    // Foreign / illegal commands: hash op, write for SHA, read sourced by SHA
    a0 = acks_seen; m0 = memops;
    issue_cmd(24'h000300, 2'b01, 2'b00, 2'b11, 0);
    issue_cmd(24'h000300, ID_SHA, 2'b00, 2'b10, 0);
    issue_cmd(24'h000300, 2'b00, ID_SHA, 2'b01, 0);
    repeat (10) @(negedge clk);
    chk("illegal_no_ack", acks_seen - a0, 0);
    chk("illegal_no_mem", memops - m0, 0);
    chk("illegal_idle", bus.cmd_ready, 1'b1);

    // cmd_valid held with another command during a read must be ignored
    a0 = acks_seen;
    issue_cmd(24'h000300, 2'b11, 2'b00, 2'b01, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {24'h000400, 2'b00, 2'b00, 2'b00, 2'b10};
    repeat (30) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done("midcmd", 3000);
    chk("midcmd_ack_count", acks_seen - a0, 1);

    // Address wrap at the top of the space
    issue_cmd(24'hFFFFF0, 2'b01, 2'b00, 2'b01, 0);
    wait_done("wrap", 3000);

    // Async reset at byte 10 of a read
    a0 = acks_seen;
    m0 = tx_seen;
    issue_cmd(24'h000500, 2'b01, 2'b00, 2'b01, 0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_seen - m0 >= 10) break;
    end
    chk("reset_reached_byte10", tx_seen - m0, 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", out_vec(), RESET_VEC);
    exp_mem.delete(); exp_tx.delete(); rx_q.delete(); exp_acks = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset_no_ack", acks_seen - a0, 0);
    rst_n = 1'b1;
    issue_cmd(24'h000010, 2'b01, 2'b00, 2'b01, 0);
    wait_done("after_reset", 3000);

    // Randomized mix of legal and foreign commands
    rand_ready = 1;
    for (int n = 0; n < 10; n++) begin
      logic [23:0] ra;
      logic [1:0]  rop, rsrc, rdst;
      ra   = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFFE0 + $urandom_range(0, 31))
                                         : 24'($urandom());
      rop  = 2'($urandom_range(0, 3));
      rsrc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rdst = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if (rop == 2'b01) rdst = 2'($urandom_range(0, 3));
      mem_lat = $urandom_range(0, 3);
      issue_cmd(ra, rdst, rsrc, rop, 0);
      wait_done("random", 4000);
    end
    rand_ready = 0;
    mem_lat = 0;

`ifdef MEM_CMD_RESPONDER_TIMEOUT_EN
    // Memory never acks: watchdog fires after 255 request cycles
    mem_hang = 1;
    exp_err = 1;
    a0 = acks_seen;
    m0 = err_seen;
    issue_cmd(24'h000600, 2'b01, 2'b00, 2'b01, 0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (acks_seen != a0) break;
    end
    chk("timeout_ack", acks_seen - a0, 1);
    chk("timeout_err_pulses", err_seen - m0, 1);
    chk("timeout_latency", ack_cyc - accept_cyc, 255);
    repeat (2) @(negedge clk);
    chk("timeout_idle", bus.cmd_ready, 1'b1);
    mem_hang = 0;
    exp_err = 0;
    issue_cmd(24'h000700, 2'b01, 2'b00, 2'b01, 0);
    wait_done("after_timeout", 3000);
`else
    chk("err_never", err_seen, 0);
`endif

    chk("queues_empty", exp_mem.size() + exp_tx.size() + exp_acks, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_cmd_responder.md
Name: mem_cmd_responder

Overview:
- Memory-side responder on the shared command/data bus.
- Decodes 32-bit command words driven by accelerator FSMs when they own the bus, and executes memory-read (stream bytes out) and memory-write (collect bytes in) transfers against a byte-wide memory port.
- Returns completion as a one-cycle ack_out = {1'b1, MEM_ID}.
- Sits between the bus arbiter/data bus and the external memory controller (QSPI/PSRAM).

Parameters:
- ADDRW, 24, address width of the command address field and mem_addr.
- MEM_ID, 2'b00, bus ID of this responder.
- RD_BYTES, 64, bytes streamed per read command (one SHA block).
- WR_BYTES, 32, bytes accepted per write command (one SHA-256 digest).
- TIMEOUT_CYCLES, 255, mem_ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command word valid (bus owner driving, grant held)
- cmd_data  in  ADDRW+8  command {addr[ADDRW+7:8], rsvd[7:6], dest[5:4], src[3:2], op[1:0]}
- cmd_ready  out  1  responder idle, command accepted this cycle when cmd_valid is high
- ack_out  out  3  {done, MEM_ID}; 3'b000 when not pulsing
- tx_data  out  8  read byte to data bus
- tx_dest  out  2  dest ID latched from the read command
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts byte
- rx_data  in  8  write byte from data bus
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  responder accepts byte
- mem_req  out  1  single-byte memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRW  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid with mem_ack
- mem_ack  in  1  access complete (one-cycle pulse)
- err_out  out  1  timeout abort pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset state: IDLE. cmd_ready=1. All other outputs 0, counters 0, latched command 0.
- Decode, only in IDLE with cmd_valid=1:
  - READ: op==2'b01 and src==MEM_ID.
  - WRITE: op==2'b10 and dest==MEM_ID.
  - Anything else (op 00/11, ID mismatch, e.g. hash op) is accepted and dropped: stay IDLE, no ack.
- On a legal command: latch addr, dest (READ) and op; clear byte count cnt; cmd_ready=0 until return to IDLE.
- States: IDLE, RD_REQ, RD_SEND, WR_RECV, WR_REQ, ACK.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr=addr+cnt (mod 2^ADDRW, wraps).
  - Hold until mem_ack, then capture mem_rdata into tx_data and go RD_SEND. mem_req drops the cycle after mem_ack.
- RD_SEND:
  - tx_valid=1; tx_data/tx_dest stable until tx_valid&&tx_ready.
  - On handshake: cnt++. If cnt==RD_BYTES-1 go ACK, else RD_REQ.
  - Minimum 2 cycles/byte with zero-wait memory.
- WR_RECV:
  - rx_ready=1. On rx_valid&&rx_ready: capture rx_data into mem_wdata, go WR_REQ.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr=addr+cnt.
  - On mem_ack: cnt++. If cnt==WR_BYTES-1 go ACK, else WR_RECV.
- ACK: ack_out={1'b1,MEM_ID} for exactly one cycle, then IDLE (cmd_ready=1 the next cycle).
- cnt width is $clog2(max(RD_BYTES,WR_BYTES))+1. Address wraps silently at 2^ADDRW-1 → 0.
- cmd_valid outside IDLE is ignored; there is no queuing. Initiators hold cmd_valid until they see ack.
- A new command is accepted only the cycle after ACK, never in the ACK cycle itself.
- mem_ack outside RD_REQ/WR_REQ is ignored. rx_valid outside WR_RECV is not accepted (rx_ready=0).
- Async reset mid-transfer returns to IDLE immediately: mem_req/tx_valid drop, no ack, partial writes are not rolled back.

Optional Feature:
- Macro: MEM_CMD_RESPONDER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in RD_REQ/WR_REQ with no mem_ack.
  - On reaching TIMEOUT_CYCLES: drop mem_req, pulse err_out 1 cycle, go ACK. The ack is still issued so the initiator FSM does not hang.
  - The watchdog clears on every mem_ack and on state entry.
- Undefined: no watchdog; err_out tied 0; a missing mem_ack hangs the block in *_REQ until reset.

Decomposition:
- Shared package sha_bus_pkg:
  - ID constants MEM_ID=2'b00, SHA_ID=2'b01.
  - Opcode constants OP_RD=2'b01, OP_WR=2'b10, OP_HASH=2'b11.
  - Command field bit positions/widths.
  - State enum typedef for this block.
- The package is shared with the initiator FSMs.
- Single module: the FSM, byte counter and address adder are too small to justify a sub-module.

Test Plan:
- Read: cmd_data={24'h000100,2'b00,2'b01,2'b00,2'b01}, memory byte[i]=i, tx_ready=1 → 64 bytes 0x00..0x3F on tx_data with tx_dest=01, mem_addr 0x000100..0x00013F, then ack_out=3'b100 for 1 cycle, cmd_ready=1 next cycle.
- Write: cmd {24'h000200,00,00,01,10}, 32 rx bytes 0xA0+i with random rx_valid gaps → mem writes addr 0x000200+i data 0xA0+i in order, single ack pulse 3'b100.
- Backpressure/wait states: tx_ready low 5 cycles on byte 3, mem_ack delayed 3 cycles → tx_data/tx_dest held stable, mem_req held until ack, no byte lost or duplicated.
- Illegal/foreign: op=2'b11 (hash) and a write with dest=01 → accepted, no mem_req, no ack, stays IDLE. cmd_valid asserted mid-transfer → ignored.
- Wrap and reset: read at addr 24'hFFFFF0 → mem_addr wraps to 0x000000 after 16 bytes. Assert rst_n low at byte 10 → all outputs 0 immediately, no ack, next command executes normally.
- With MEM_CMD_RESPONDER_TIMEOUT_EN: mem_ack never returned → after 255 cycles err_out pulse, ack_out=3'b100, return to IDLE.
